regfile_sync: RTL



---
 rtl/regfile_sync.sv | 104 ++++++++++
 1 files changed

// File: rtl/regfile_sync.sv
// Synchronous register file: two registered read ports, one write port, one req/ack transaction per clock.
// A clear sequencer zeroes all entries after reset. Optional macro REGFILE_BYPASS_EN adds write-first read bypass.
module regfile_sync #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req,
  input  logic                     rs_read,
  input  logic [$clog2(NREGS)-1:0] rs1_in,
  input  logic [$clog2(NREGS)-1:0] rs2_in,
  input  logic [$clog2(NREGS)-1:0] rd_in,
  input  logic                     rd_write_in,
  input  logic [XLEN-1:0]          rd_value_in,
  output logic                     ack,
  output logic                     busy,
  output logic [XLEN-1:0]          rs1_value_out,
  output logic [XLEN-1:0]          rs2_value_out
);
  localparam int AW = $clog2(NREGS);
  localparam logic [AW:0] NR = NREGS[AW:0];

  typedef enum logic {CLEAR, RUN} state_t;

  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_cnt, w_cnt_nxt;
  logic [XLEN-1:0] r_mem [NREGS];
  logic            r_ack;
  logic [XLEN-1:0] r_rs1, r_rs2;

  logic            w_acc, w_we, w_byp1, w_byp2;
  logic [AW-1:0]   w_widx;
  logic [XLEN-1:0] w_wdata, w_rs1, w_rs2;

  // Index is backed by real storage and is not the hardwired-zero entry.
  function automatic logic idx_ok(input logic [AW-1:0] idx);
    return ({1'b0, idx} < NR) && !((ZERO_REG != 0) && (idx == '0));
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_acc       = 1'b0;
    w_we        = 1'b0;
    w_widx      = rd_in;
    w_wdata     = rd_value_in;
    case (r_state)
      CLEAR: begin
        w_we      = 1'b1;
        w_widx    = r_cnt;
        w_wdata   = '0;
        w_cnt_nxt = r_cnt + 1'b1;
        if ({1'b0, r_cnt} == NR - 1'b1) w_state_nxt = RUN;
      end
      RUN: begin
        w_acc = req;
        w_we  = req && !rd_write_in && idx_ok(rd_in);
      end
      default: w_state_nxt = CLEAR;
    endcase
  end

  assign w_rs1 = idx_ok(rs1_in) ? r_mem[rs1_in] : '0;
  assign w_rs2 = idx_ok(rs2_in) ? r_mem[rs2_in] : '0;

`ifdef REGFILE_BYPASS_EN
  // w_we only carries a host write while w_acc is set, so it already implies a writable rd_in.
  assign w_byp1 = w_acc && w_we && (rs1_in == rd_in);
  assign w_byp2 = w_acc && w_we && (rs2_in == rd_in);
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
      r_ack   <= 1'b0;
      r_rs1   <= '0;
      r_rs2   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ack   <= w_acc;
      if (w_acc && !rs_read) begin
        r_rs1 <= w_byp1 ? rd_value_in : w_rs1;
        r_rs2 <= w_byp2 ? rd_value_in : w_rs2;
      end
    end
  end

  // Storage has no reset; the clear sequencer zeroes it, and a reset edge drops any write.
  always_ff @(posedge clk) begin
    if (w_we && !rst) r_mem[w_widx] <= w_wdata;
  end

  assign ack           = r_ack;
  assign busy          = (r_state == CLEAR);
  assign rs1_value_out = r_rs1;
  assign rs2_value_out = r_rs2;
endmodule
